// File: rtl/cs_cpa_pipe.sv
// rtl/cs_cpa_pipe.sv - segmented pipelined carry-propagate adder resolving a carry-save pair
module cs_cpa_pipe #(
    parameter int WIDTH = 8,
    parameter int SEG   = 4,
    localparam int PW   = 2 * WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] sum_in,
    input  logic [PW-1:0] carry_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] product,
    output logic          cout
);
    localparam int NSEG = PW / SEG;

    generate
        if (PW % SEG != 0) begin : g_seg_check
            $error("cs_cpa_pipe: 2*WIDTH must be a multiple of SEG");
        end
    endgenerate

    // Stage k holds resolved bits [(k+1)*SEG-1:0] in res, the raw vectors for the
    // upper segments in sum/car, and the carry into segment k+1 in cy.
    logic [NSEG-1:0][PW-1:0] res_q, res_d, sum_q, sum_d, car_q, car_d;
    logic [NSEG-1:0][PW-1:0] src_res, src_sum, src_car;
    logic [NSEG-1:0]         cy_q, cy_d, vld_q, vld_d, src_cy, src_vld;
    logic [NSEG-1:0][SEG:0]  seg_s;
    logic                    adv;

    always_comb begin
        adv   = !vld_q[NSEG-1] || out_ready;
        res_d = res_q;
        sum_d = sum_q;
        car_d = car_q;
        cy_d  = cy_q;
        vld_d = vld_q;
        seg_s = '0;

        src_res    = '0;
        src_sum    = '0;
        src_car    = '0;
        src_cy     = '0;
        src_vld    = '0;
        src_sum[0] = sum_in;
        src_car[0] = carry_in;
        src_vld[0] = in_valid;
        for (int k = 1; k < NSEG; k++) begin
            src_res[k] = res_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_car[k] = car_q[k-1];
            src_cy[k]  = cy_q[k-1];
            src_vld[k] = vld_q[k-1];
        end

        for (int k = 0; k < NSEG; k++) begin
            seg_s[k] = {1'b0, src_sum[k][k*SEG +: SEG]}
                     + {1'b0, src_car[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, src_cy[k]};
            if (adv) begin
                vld_d[k] = src_vld[k];
                // The output stage only loads data when a valid beat lands in it.
                if (k != NSEG - 1 || src_vld[k]) begin
                    res_d[k]               = src_res[k];
                    res_d[k][k*SEG +: SEG] = seg_s[k][SEG-1:0];
                    cy_d[k]                = seg_s[k][SEG];
                    sum_d[k]               = src_sum[k];
                    car_d[k]               = src_car[k];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            res_q <= '0;
            sum_q <= '0;
            car_q <= '0;
            cy_q  <= '0;
            vld_q <= '0;
        end else begin
            res_q <= res_d;
            sum_q <= sum_d;
            car_q <= car_d;
            cy_q  <= cy_d;
            vld_q <= vld_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[NSEG-1];
    assign product   = res_q[NSEG-1];
    assign cout      = cy_q[NSEG-1];
endmodule

// File: doc/cs_cpa_pipe.md
Name: cs_cpa_pipe

Overview:
- Pipelined, segmented carry-propagate adder that resolves the carry-save output of the registered radix-4 Booth multiplier stage (its registered sum and carry vectors) into a final two's-complement product.
- Sits directly downstream of the multiplier wrapper.
- Adds one SEG-bit segment per pipeline stage, rippling the inter-segment carry through registers.
- Provides valid/ready flow control so a downstream consumer can stall it.

Parameters:
- WIDTH, 8, multiplier operand width. Internal PW = 2*WIDTH is the product/vector width.
- SEG, 4, bits resolved per pipeline stage. PW must be an integer multiple of SEG; otherwise elaboration fails.
- NSEG (local, derived), PW/SEG, number of stages, which equals the latency.

Ports:
- CLK, input, 1, single clock; all state updates on the rising edge.
- RST, input, 1, synchronous active-high reset.
- in_valid, input, 1, sum_in/carry_in hold a valid carry-save pair.
- in_ready, output, 1, block accepts the pair on this cycle.
- sum_in, input, PW, carry-save sum vector.
- carry_in, input, PW, carry-save carry vector, already weight-aligned (no internal shift).
- out_valid, output, 1, product/cout are valid.
- out_ready, input, 1, downstream accepts the result.
- product, output, PW, (sum_in + carry_in) mod 2^PW.
- cout, output, 1, carry out of bit PW-1 (diagnostic; ignored for signed products).

Behaviour:
- Reset: while RST is high at a clock edge, all stage valid bits clear, and product, cout and all internal data/carry registers go to 0. out_valid = 0 the cycle after reset. RST overrides all other inputs and flushes any in-flight data; flushed data is never output.
- Advance enable: adv = !out_valid || out_ready. This is a global stall: all stages advance together when adv = 1 and all hold when adv = 0.
- in_ready = adv, combinational. Acceptance occurs when in_valid && in_ready.
- Stage 0 on accept:
  - Resolves segment 0: {c0, r0} = sum_in[SEG-1:0] + carry_in[SEG-1:0].
  - Registers r0, c0, and the unresolved upper bits of both vectors.
  - Sets valid0 = in_valid. A bubble enters when in_valid = 0 and adv = 1.
- Stage k (1..NSEG-1) on adv:
  - Resolves segment k: sum_seg + carry_seg + c(k-1).
  - Passes the already-resolved lower segments forward unchanged, and delays the still-unresolved upper bits.
  - valid(k) = valid(k-1).
- The final stage registers product, cout and out_valid. Latency from accept to out_valid is NSEG cycles when there are no stalls. Throughput is one result per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, product, cout, out_valid and all stage registers hold, in_ready = 0, and no input is lost or duplicated.
- Bubbles: invalid stages still shift. Data in invalid stages is don't-care; product updates only when a valid beat reaches the output.
- Ordering: strictly in-order; results are never dropped, reordered or duplicated.
- Arithmetic: unsigned modulo-2^PW addition. The signed product is the PW-bit result read as two's complement. cout is the raw carry out of the MSB segment.
- Full carry ripple: a carry generated in segment 0 must propagate through all NSEG segments with no shortcut. The result must be correct for any 0xFFFF+0x0001-type pattern.

Test Plan (WIDTH=8, SEG=4, so PW=16 and latency 4):
- Reset, then one beat sum_in=16'h00FF, carry_in=16'h0001, out_ready=1 -> exactly 4 cycles after accept, out_valid=1, product=16'h0100, cout=0; out_valid=0 on the next cycle.
- Full ripple: sum_in=16'hFFFF, carry_in=16'h0001 -> product=16'h0000, cout=1. Also sum_in=16'h8000, carry_in=16'h8000 -> product=16'h0000, cout=1.
- Signed result: a pair summing to -15, e.g. sum_in=16'hFFF0, carry_in=16'h0001 -> product=16'hFFF1, cout=0. Also a random Booth pair from the multiplier stage -> product equals the signed mx*my.
- Back-to-back: 8 consecutive beats with out_ready=1 and in_valid held high -> 8 results on 8 consecutive cycles, in order, first at cycle 4; in_ready stays 1 throughout.
- Stall: out_ready=0 when the first result appears, while 3 more beats are in flight -> product held, in_ready=0. Release after 5 cycles -> the remaining results emerge in order on consecutive cycles with none lost.
- Reset mid-flight: 3 beats accepted, then RST=1 for 1 cycle -> out_valid=0 and product=0 the cycle after reset, no stale results afterwards, and a new beat gives correct output at latency 4.
